// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the pipeline hazard controller.
// Contents:
//   OP_NOP / OP_BNE  : decode opcodes the hazard logic reacts to
//   hazard_state_t   : front-end control FSM states (RUN, FLUSH)
//   PERF_W           : width of the stall / flush performance counters
//   sat_inc()        : saturating increment used by the performance counters
package cpu_hazard_pkg;

  localparam logic [4:0] OP_NOP = 5'b00000;
  localparam logic [4:0] OP_BNE = 5'b00011;

  localparam int PERF_W = 16;

  typedef enum logic {
    RUN,
    FLUSH
  } hazard_state_t;

  // Counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (value == '1) ? value : value + PERF_W'(1);
  endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Decode-side bus between the decode stage and the hazard controller.
// Signals:
//   valid_decode, opcode_decode, rs1_decode, rs2_decode, rd_decode,
//   load_decode, regfile_data_1, regfile_data_2 : decode-stage instruction info
//   stall, flush_ifid, branch_taken             : pipeline control back to the core
//   stall_count, flush_count                    : performance counters
// Modports:
//   master : decode stage (drives instruction info, receives control)
//   slave  : hazard controller
interface hazard_control_unit_if
  import cpu_hazard_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 5,
  parameter int OPCODE_W   = 5
) ();

  logic                  valid_decode;
  logic [OPCODE_W-1:0]   opcode_decode;
  logic [REG_ADDR_W-1:0] rs1_decode;
  logic [REG_ADDR_W-1:0] rs2_decode;
  logic [REG_ADDR_W-1:0] rd_decode;
  logic                  load_decode;
  logic [DATA_W-1:0]     regfile_data_1;
  logic [DATA_W-1:0]     regfile_data_2;
  logic                  stall;
  logic                  flush_ifid;
  logic                  branch_taken;
  logic [PERF_W-1:0]     stall_count;
  logic [PERF_W-1:0]     flush_count;

  modport master (
    output valid_decode, opcode_decode, rs1_decode, rs2_decode, rd_decode,
           load_decode, regfile_data_1, regfile_data_2,
    input  stall, flush_ifid, branch_taken, stall_count, flush_count
  );

  modport slave (
    input  valid_decode, opcode_decode, rs1_decode, rs2_decode, rd_decode,
           load_decode, regfile_data_1, regfile_data_2,
    output stall, flush_ifid, branch_taken, stall_count, flush_count
  );

endinterface

// File: rtl/hazard_control_unit_scoreboard.sv
// Per-register load countdown scoreboard.
// A register is busy while its counter is nonzero; r0 is never busy.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   set_en, set_addr    : an issuing load reloads the counter of set_addr
//   rs1_addr, rs2_addr  : decode source registers to look up
//   rs1_busy, rs2_busy  : source register still waiting on a load
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LOAD_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_addr,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  output logic                  rs1_busy,
  output logic                  rs2_busy
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int CNT_W    = $clog2(LOAD_LAT + 1);

  logic [CNT_W-1:0] cnt [NUM_REGS];

  // A fresh load on a register overrides that register's decrement in the
  // same cycle, so back-to-back loads to one register restart the countdown.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (set_en && (set_addr == REG_ADDR_W'(i))) begin
          cnt[i] <= CNT_W'(LOAD_LAT);
        end else if (cnt[i] != '0) begin
          cnt[i] <= cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  assign rs1_busy = (rs1_addr != '0) && (cnt[rs1_addr] != '0);
  assign rs2_busy = (rs2_addr != '0) && (cnt[rs2_addr] != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller beside the decode stage: stalls load-use
// dependences for LOAD_LAT cycles, resolves bne in decode and holds the
// IF/ID flush for FLUSH_CYCLES cycles after a taken branch.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset; forces stall/flush/branch low
//   hz    : decode bus (slave side), see hazard_control_unit_if
// Optional build macro:
//   HAZARD_PERF_EN : when defined, stall_count / flush_count are saturating
//                    counters; otherwise both read 16'h0000 and no flops exist.
module hazard_control_unit
  import cpu_hazard_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int REG_ADDR_W   = 5,
  parameter int OPCODE_W     = 5,
  parameter int LOAD_LAT     = 1,
  parameter int FLUSH_CYCLES = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_control_unit_if.slave hz
);

  hazard_state_t     state, state_next;
  logic [2:0]        flush_left, flush_left_next;
  logic [DATA_W-1:0] data_1, data_2;
  logic              live, rs1_busy, rs2_busy;
  logic              stall, taken, issue_load, flush_out;

  assign data_1 = hz.regfile_data_1;
  assign data_2 = hz.regfile_data_2;

  // Decode only counts while out of reset and not in the middle of a flush.
  assign live = rst_n && hz.valid_decode && (state == RUN) &&
                (hz.opcode_decode != OPCODE_W'(OP_NOP));

  assign stall      = live && (rs1_busy || rs2_busy);
  assign taken      = live && !stall && (hz.opcode_decode == OPCODE_W'(OP_BNE)) &&
                      (data_1 != data_2);
  assign issue_load = live && !stall && hz.load_decode && (hz.rd_decode != '0);

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .LOAD_LAT   (LOAD_LAT)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_en   (issue_load),
    .set_addr (hz.rd_decode),
    .rs1_addr (hz.rs1_decode),
    .rs2_addr (hz.rs2_decode),
    .rs1_busy (rs1_busy),
    .rs2_busy (rs2_busy)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_left <= '0;
    end else begin
      state      <= state_next;
      flush_left <= flush_left_next;
    end
  end

  // The branch cycle itself is the first flush cycle, so FLUSH only covers
  // the remaining FLUSH_CYCLES-1 cycles.
  always_comb begin
    state_next      = state;
    flush_left_next = flush_left;
    flush_out       = 1'b0;
    case (state)
      RUN: begin
        if (taken) begin
          flush_out = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_next      = FLUSH;
            flush_left_next = 3'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        flush_out = rst_n;
        if (flush_left <= 3'd1) begin
          state_next = RUN;
        end else begin
          flush_left_next = flush_left - 3'd1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  assign hz.stall        = stall;
  assign hz.flush_ifid   = flush_out;
  assign hz.branch_taken = taken;

`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;

  // Each counter records the cycle that is ending at this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (taken) flush_cnt_q <= sat_inc(flush_cnt_q);
    end
  end

  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;
`else
  assign hz.stall_count = '0;
  assign hz.flush_count = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with two instances:
//   dut_a : LOAD_LAT=1, FLUSH_CYCLES=2
//   dut_b : LOAD_LAT=3, FLUSH_CYCLES=1
// Expected control outputs are queued when a step is driven and popped when
// the outputs are sampled on the falling edge.
module tb_hazard_control_unit;
  import cpu_hazard_pkg::*;

  localparam logic [4:0] OP_ADD = 5'd1;
  localparam logic [4:0] OP_LD  = 5'd2;

`ifdef HAZARD_PERF_EN
  localparam logic [15:0] EXP_STALLS = 16'd3;
  localparam logic [15:0] EXP_FLUSHES = 16'd2;
`else
  localparam logic [15:0] EXP_STALLS = 16'd0;
  localparam logic [15:0] EXP_FLUSHES = 16'd0;
`endif

  typedef struct packed {
    logic stall;
    logic flush;
    logic taken;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  hazard_control_unit_if #(.DATA_W(16), .REG_ADDR_W(5), .OPCODE_W(5)) if_a ();
  hazard_control_unit_if #(.DATA_W(16), .REG_ADDR_W(5), .OPCODE_W(5)) if_b ();

  hazard_control_unit #(
    .DATA_W(16), .REG_ADDR_W(5), .OPCODE_W(5), .LOAD_LAT(1), .FLUSH_CYCLES(2)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_a)
  );

  hazard_control_unit #(
    .DATA_W(16), .REG_ADDR_W(5), .OPCODE_W(5), .LOAD_LAT(3), .FLUSH_CYCLES(1)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (if_b)
  );

  // Drives the selected instance; the other one sees an invalid slot.
  task automatic applyStimulus(input int which, input logic v, input logic [4:0] op,
                               input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] rd, input logic ld,
                               input logic [15:0] d1, input logic [15:0] d2);
    if_a.valid_decode   = (which == 0) ? v : 1'b0;
    if_a.opcode_decode  = (which == 0) ? op : OP_NOP;
    if_a.rs1_decode     = (which == 0) ? rs1 : 5'd0;
    if_a.rs2_decode     = (which == 0) ? rs2 : 5'd0;
    if_a.rd_decode      = (which == 0) ? rd : 5'd0;
    if_a.load_decode    = (which == 0) ? ld : 1'b0;
    if_a.regfile_data_1 = (which == 0) ? d1 : 16'h0;
    if_a.regfile_data_2 = (which == 0) ? d2 : 16'h0;
    if_b.valid_decode   = (which == 1) ? v : 1'b0;
    if_b.opcode_decode  = (which == 1) ? op : OP_NOP;
    if_b.rs1_decode     = (which == 1) ? rs1 : 5'd0;
    if_b.rs2_decode     = (which == 1) ? rs2 : 5'd0;
    if_b.rd_decode      = (which == 1) ? rd : 5'd0;
    if_b.load_decode    = (which == 1) ? ld : 1'b0;
    if_b.regfile_data_1 = (which == 1) ? d1 : 16'h0;
    if_b.regfile_data_2 = (which == 1) ? d2 : 16'h0;
  endtask

  task automatic expectOut(input logic s, input logic f, input logic t);
    exp_t e;
    e.stall = s;
    e.flush = f;
    e.taken = t;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input int which, input string tag);
    exp_t e;
    exp_t obs;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL %s: no expected entry queued, got %b", tag, obs);
      return;
    end
    e = exp_q.pop_front();
    if (which == 0) obs = {if_a.stall, if_a.flush_ifid, if_a.branch_taken};
    else            obs = {if_b.stall, if_b.flush_ifid, if_b.branch_taken};
    assert (obs === e) else begin
      bad++;
      $error("[TB] FAIL %s: stall/flush/taken got=%b required=%b", tag, obs, e);
    end
  endtask

  task automatic checkCount(input string tag, input logic [15:0] obs, input logic [15:0] e);
    total++;
    assert (obs === e) else begin
      bad++;
      $error("[TB] FAIL %s: got=%0d required=%0d", tag, obs, e);
    end
  endtask

  // One decode cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input int which, input logic v, input logic [4:0] op,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                      input logic ld, input logic [15:0] d1, input logic [15:0] d2,
                      input logic s, input logic f, input logic t, input string tag);
    applyStimulus(which, v, op, rs1, rs2, rd, ld, d1, d2);
    expectOut(s, f, t);
    @(negedge clk);
    checkOutput(which, tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(0, 1'b0, OP_NOP, 5'd0, 5'd0, 5'd0, 1'b0, 16'h0, 16'h0);
    @(posedge clk);
    #1;
    // Reset held: a taken-looking bne must not produce any control output.
    applyStimulus(0, 1'b1, OP_BNE, 5'd1, 5'd2, 5'd0, 1'b0, 16'h1, 16'h2);
    expectOut(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput(0, "rst_forced_a");
    checkCount("rst_stall_cnt_a", if_a.stall_count, 16'd0);
    checkCount("rst_flush_cnt_b", if_b.flush_count, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Load-use, single bubble (dut_a)
    step(0, 1, OP_LD,  5'd0, 5'd0, 5'd3, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r3");
    step(0, 1, OP_ADD, 5'd3, 5'd0, 5'd6, 0, 16'h0, 16'h0, 1, 0, 0, "use_r3_stall");
    step(0, 1, OP_ADD, 5'd3, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "use_r3_go");
    step(0, 1, OP_LD,  5'd0, 5'd0, 5'd3, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r3_again");
    step(0, 1, OP_ADD, 5'd4, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "indep_r4");

    // Load-use, three cycle latency (dut_b)
    step(1, 1, OP_LD,  5'd0, 5'd0, 5'd5, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r5");
    for (int i = 0; i < 3; i++)
      step(1, 1, OP_ADD, 5'd0, 5'd5, 5'd6, 0, 16'h0, 16'h0, 1, 0, 0, "use_r5_stall");
    step(1, 1, OP_ADD, 5'd0, 5'd5, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "use_r5_go");
    step(1, 1, OP_LD,  5'd0, 5'd0, 5'd0, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r0");
    step(1, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "use_r0");
    step(1, 1, OP_NOP, 5'd0, 5'd0, 5'd7, 1, 16'h0, 16'h0, 0, 0, 0, "nop_ld_r7");
    step(1, 1, OP_ADD, 5'd7, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "use_r7");
    // NOP ignores a busy source; a stalled load must not claim its rd.
    step(1, 1, OP_LD,  5'd0, 5'd0, 5'd9, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r9");
    step(1, 1, OP_NOP, 5'd9, 5'd0, 5'd0, 0, 16'h0, 16'h0, 0, 0, 0, "nop_reads_r9");
    step(1, 1, OP_LD,  5'd9, 5'd0, 5'd11, 1, 16'h0, 16'h0, 1, 0, 0, "stalled_ld_r11");
    step(1, 1, OP_ADD, 5'd11, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "use_r11");
    step(1, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "drain_r9");

    // Taken and not-taken bne, two-cycle flush (dut_a)
    step(0, 1, OP_BNE, 5'd1, 5'd2, 5'd0, 0, 16'h0001, 16'h0002, 0, 1, 1, "bne_taken");
    step(0, 1, OP_LD,  5'd0, 5'd0, 5'd9, 1, 16'h0, 16'h0, 0, 1, 0, "flush_hold_ld_r9");
    step(0, 1, OP_ADD, 5'd9, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "after_flush_r9");
    step(0, 1, OP_BNE, 5'd1, 5'd2, 5'd0, 0, 16'h0005, 16'h0005, 0, 0, 0, "bne_equal");

    // Branch behind a load (dut_a)
    step(0, 1, OP_LD,  5'd0, 5'd0, 5'd2, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r2");
    step(0, 1, OP_BNE, 5'd2, 5'd0, 5'd0, 0, 16'h0001, 16'h0002, 1, 0, 0, "bne_wait");
    step(0, 1, OP_BNE, 5'd2, 5'd0, 5'd0, 0, 16'h0001, 16'h0002, 0, 1, 1, "bne_go");
    step(0, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 1, 0, "bne_flush2");
    step(0, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "bne_done");

    // Reset with a busy register in dut_b and dut_a mid-flush
    step(1, 1, OP_LD,  5'd0, 5'd0, 5'd8, 1, 16'h0, 16'h0, 0, 0, 0, "ld_r8");
    step(0, 1, OP_BNE, 5'd1, 5'd2, 5'd0, 0, 16'h0001, 16'h0002, 0, 1, 1, "bne_before_rst");
    rst_n = 1'b0;
    applyStimulus(1, 1'b1, OP_ADD, 5'd8, 5'd0, 5'd6, 1'b0, 16'h0, 16'h0);
    expectOut(1'b0, 1'b0, 1'b0);
    expectOut(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput(1, "rst_forced_b");
    checkOutput(0, "rst_forced_flush_a");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkCount("post_rst_stall_cnt_a", if_a.stall_count, 16'd0);
    checkCount("post_rst_flush_cnt_a", if_a.flush_count, 16'd0);
    step(1, 1, OP_ADD, 5'd8, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "post_rst_r8");
    step(0, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "post_rst_a_run");

    // Performance counters: 3 stall cycles and 2 taken branches on dut_b
    step(1, 1, OP_LD,  5'd0, 5'd0, 5'd10, 1, 16'h0, 16'h0, 0, 0, 0, "perf_ld");
    for (int i = 0; i < 3; i++)
      step(1, 1, OP_ADD, 5'd10, 5'd0, 5'd6, 0, 16'h0, 16'h0, 1, 0, 0, "perf_stall");
    step(1, 1, OP_ADD, 5'd10, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "perf_go");
    step(1, 1, OP_BNE, 5'd1, 5'd2, 5'd0, 0, 16'h0003, 16'h0004, 0, 1, 1, "perf_bne1");
    step(1, 1, OP_BNE, 5'd1, 5'd2, 5'd0, 0, 16'h0003, 16'h0004, 0, 1, 1, "perf_bne2");
    step(1, 1, OP_ADD, 5'd0, 5'd0, 5'd6, 0, 16'h0, 16'h0, 0, 0, 0, "perf_idle");
    checkCount("perf_stall_count", if_b.stall_count, EXP_STALLS);
    checkCount("perf_flush_count", if_b.flush_count, EXP_FLUSHES);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Parametrised pipeline hazard controller for the 5-stage CPU core, sitting beside the decode stage. It tracks outstanding loads in a per-register countdown scoreboard to stall dependent instructions for a configurable load-use latency. It resolves `bne` in decode and drives a multi-cycle flush of the front-end. It generalises the single-bubble load-use / single-flush behaviour to arbitrary register count, data width, load latency and flush depth.

## Interface
Parameters:
- `DATA_W`, 16: register file data width.
- `REG_ADDR_W`, 5: register index width; `2**REG_ADDR_W` registers, r0 never tracked.
- `OPCODE_W`, 5: opcode width.
- `LOAD_LAT`, 1: number of cycles a load result is unavailable to a decode-stage reader. Range 1..7.
- `FLUSH_CYCLES`, 1: number of cycles `flush_ifid` is held after a taken branch. Range 1..4.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset.
- `valid_decode`  in  1: decode-stage instruction is valid.
- `opcode_decode`  in  OPCODE_W: decode-stage opcode.
- `rs1_decode`, `rs2_decode`  in  REG_ADDR_W: decode source registers.
- `rd_decode`  in  REG_ADDR_W: decode destination register.
- `load_decode`  in  1: decode instruction is a load writing `rd_decode`.
- `regfile_data_1`, `regfile_data_2`  in  DATA_W: operands read in decode, used for `bne`.
- `stall`  out  1: hold PC and IF/ID, and insert a bubble into ID/EX.
- `flush_ifid`  out  1: zero the IF/ID pipeline register.
- `branch_taken`  out  1: single-cycle pulse, redirect PC to the branch target.
- `stall_count`  out  16: saturating count of stall cycles.
- `flush_count`  out  16: saturating count of taken branches.

## Operation
- Decode is *live* when `valid_decode` is high, the FSM is in RUN, and the opcode is not `OP_NOP`.
- **Scoreboard:** one counter per register, each `$clog2(LOAD_LAT+1)` bits wide.
  - Every edge, each nonzero counter decrements by 1.
  - An issuing load (live, `load_decode`, not stalled, `rd_decode != 0`) sets `cnt[rd_decode] = LOAD_LAT`. The set wins over the decrement for the same register.
- **Stall:** `stall = live & ((rs1_decode != 0 & cnt[rs1_decode] != 0) | (rs2_decode != 0 & cnt[rs2_decode] != 0))`.
  - A stalled load does not issue.
- **Branch:** taken when live, `opcode_decode == OP_BNE`, `regfile_data_1 != regfile_data_2`, and not stalled.
  - Stall has priority: a branch whose operands are busy waits; it is evaluated only once no longer stalled.
- **FSM states:** RUN, FLUSH.
  - RUN: on a taken branch, assert `flush_ifid` and `branch_taken`. Go to FLUSH if `FLUSH_CYCLES > 1`, else stay in RUN.
  - FLUSH: hold `flush_ifid` high. An internal counter, loaded with `FLUSH_CYCLES-1` on entry, decrements each cycle; return to RUN when it reaches 1.
  - In FLUSH, decode is ignored: no stall, no scoreboard set, no branch. Decrements continue.
- `OP_NOP` in decode never stalls, flushes, or sets the scoreboard.

## Timing
- `stall`, `flush_ifid` and `branch_taken` are combinational from the decode inputs plus registered state, valid in the same cycle.
- Load-use penalty:
  - A load issued in cycle t makes a dependent instruction at decode in t+1 stall exactly `LOAD_LAT` cycles.
  - With `LOAD_LAT = 1`, this gives a single bubble.
  - An independent instruction in t+1 does not stall.
- Taken-branch penalty: `flush_ifid` is high for exactly `FLUSH_CYCLES` consecutive cycles; `branch_taken` is high for the first of them only.
- Reset (`rst_n` low at an edge):
  - All scoreboard counters become 0, the FSM goes to RUN, and both perf counters become 0.
  - While `rst_n` is low, `stall`, `flush_ifid` and `branch_taken` are forced to 0.
  - Reset mid-FLUSH aborts the flush on the next edge.
- Perf counters increment at the edge ending a cycle with `stall` (respectively `branch_taken`) high, and saturate at 16'hFFFF.

## Configuration
- `HAZARD_PERF_EN` defined: `stall_count` and `flush_count` are implemented as described.
- `HAZARD_PERF_EN` undefined: no counter flops are built and both ports are tied to 16'h0000. The ports exist in both builds.

## Structure
- Package `cpu_hazard_pkg` holds:
  - opcode constants `OP_NOP = 5'b00000` and `OP_BNE = 5'b00011`;
  - the FSM state typedef `hazard_state_t` (RUN, FLUSH);
  - the perf counter width constant `PERF_W = 16`.
- Sub-module `hazard_scoreboard` contains the counter array, the set/decrement logic and the busy lookups for rs1/rs2. It is parametrised by `REG_ADDR_W` and `LOAD_LAT`.

## Test plan
- **Load-use, `LOAD_LAT=1`:** load r3 issues, then `add` with rs1=r3 at decode. Required: `stall` high for 1 cycle, then low; a reader of r4 instead sees no stall.
- **Load-use, `LOAD_LAT=3`:** load r5, then reader of r5 with rs2=5. Required: `stall` high for exactly 3 cycles. Also load to r0 followed by a reader of r0: no stall.
- **Taken `bne`, `FLUSH_CYCLES=2`:** data_1=16'h0001, data_2=16'h0002. Required: `flush_ifid` high for 2 cycles, `branch_taken` pulse of 1 cycle. With data_1 == data_2: all outputs low.
- **Branch behind load:** load r2, then `bne` reading r2 with unequal data. Required: stall for `LOAD_LAT` cycles first with no flush, then flush in the cycle after the stall clears.
- **Reset mid-operation:** `rst_n` low during FLUSH and with nonzero scoreboard counters. Required: all outputs 0 while low; after release, a reader of the previously loaded register does not stall.
- **`HAZARD_PERF_EN` build:** 3 stall cycles and 2 taken branches. Required: `stall_count` = 3, `flush_count` = 2. Without the macro, both read 0.
